// File: rtl/csr_trap_seq.sv
`default_nettype none
// ============================================================================
//  Module   : csr_trap_seq
//  Brief    : Trap entry / mret sequencer that owns the CSR write port while
//             trapping and arbitrates it against pipeline CSR instructions.
//             Optional vectored trap targets under CSR_TRAP_VECTORED_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_trap_seq #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned CAUSE_MTI = 7,
   parameter int unsigned CAUSE_MEI = 11
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      irq_i,
   input  logic            mie_bit,
   input  logic            mret_i,
   input  logic            pipe_empty_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            pipe_csr_req,
   input  logic [11:0]     pipe_csr_addr,
   input  logic [2:0]      pipe_csr_op,
   input  logic [XLEN-1:0] pipe_csr_wdata,
   output logic            pipe_csr_gnt,
   output logic            csr_en,
   output logic [11:0]     csr_addr,
   output logic [2:0]      csr_opcode,
   output logic [XLEN-1:0] csr_wdata,
   output logic            stop_fetch,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            trap_busy
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DRAIN    = 3'd1,
      S_WR_EPC   = 3'd2,
      S_WR_CAUSE = 3'd3,
      S_WR_ST    = 3'd4,
      S_RET_ST   = 3'd5,
      S_REDIR    = 3'd6
   } state_t;

   localparam logic [11:0]     c_ADDR_MSTATUS = 12'h300;
   localparam logic [11:0]     c_ADDR_MEPC    = 12'h341;
   localparam logic [11:0]     c_ADDR_MCAUSE  = 12'h342;
   localparam logic [2:0]      c_OP_RW        = 3'b001;
   localparam logic [2:0]      c_OP_RS        = 3'b010;
   localparam logic [2:0]      c_OP_RC        = 3'b011;
   localparam logic [XLEN-1:0] c_MIE_MASK     = XLEN'(8);
   localparam logic [XLEN-2:0] c_MTI          = (XLEN-1)'(CAUSE_MTI);
   localparam logic [XLEN-2:0] c_MEI          = (XLEN-1)'(CAUSE_MEI);

   state_t            r_state;
   state_t            w_next_state;
   logic [XLEN-2:0]   r_cause;
   logic [XLEN-1:0]   r_epc;
   logic [XLEN-1:0]   r_redirect_pc;

   logic              w_take_irq;
   logic              w_seq_en;
   logic [11:0]       w_seq_addr;
   logic [2:0]        w_seq_op;
   logic [XLEN-1:0]   w_seq_wdata;
   logic [XLEN-1:0]   w_trap_base;
   logic [XLEN-1:0]   w_trap_target;
   logic              w_unused_ok;

   // mret has priority over an interrupt arriving in the same cycle
   assign w_take_irq  = (r_state == S_IDLE) && !mret_i && (|irq_i) && mie_bit;
   assign w_trap_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
   assign w_trap_target = (mtvec_i[1:0] == 2'b01)
                        ? w_trap_base + {r_cause[XLEN-3:0], 2'b00}
                        : w_trap_base;
`else
   assign w_trap_target = w_trap_base;
`endif

   assign w_unused_ok = &{1'b0, mtvec_i[1:0], r_cause[XLEN-2]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_cause       <= '0;
         r_epc         <= '0;
         r_redirect_pc <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_take_irq)
            r_cause <= irq_i[1] ? c_MEI : c_MTI;
         if ((r_state == S_DRAIN) && pipe_empty_i)
            r_epc <= pc_i;
         if (r_state == S_WR_ST)
            r_redirect_pc <= w_trap_target;
         else if (r_state == S_RET_ST)
            r_redirect_pc <= mepc_i;
      end
   end

   always_comb begin
      w_next_state   = r_state;
      w_seq_en       = 1'b0;
      w_seq_addr     = '0;
      w_seq_op       = '0;
      w_seq_wdata    = '0;
      stop_fetch     = 1'b0;
      redirect_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mret_i)
               w_next_state = S_RET_ST;
            else if (w_take_irq)
               w_next_state = S_DRAIN;
         end
         S_DRAIN: begin
            stop_fetch = 1'b1;
            if (pipe_empty_i)
               w_next_state = S_WR_EPC;
         end
         S_WR_EPC: begin
            stop_fetch   = 1'b1;
            w_seq_en     = 1'b1;
            w_seq_addr   = c_ADDR_MEPC;
            w_seq_op     = c_OP_RW;
            w_seq_wdata  = r_epc;
            w_next_state = S_WR_CAUSE;
         end
         S_WR_CAUSE: begin
            stop_fetch   = 1'b1;
            w_seq_en     = 1'b1;
            w_seq_addr   = c_ADDR_MCAUSE;
            w_seq_op     = c_OP_RW;
            w_seq_wdata  = {1'b1, r_cause};
            w_next_state = S_WR_ST;
         end
         S_WR_ST: begin
            stop_fetch   = 1'b1;
            w_seq_en     = 1'b1;
            w_seq_addr   = c_ADDR_MSTATUS;
            w_seq_op     = c_OP_RC;
            w_seq_wdata  = c_MIE_MASK;
            w_next_state = S_REDIR;
         end
         S_RET_ST: begin
            stop_fetch   = 1'b1;
            w_seq_en     = 1'b1;
            w_seq_addr   = c_ADDR_MSTATUS;
            w_seq_op     = c_OP_RS;
            w_seq_wdata  = c_MIE_MASK;
            w_next_state = S_REDIR;
         end
         S_REDIR: begin
            stop_fetch     = 1'b1;
            redirect_valid = 1'b1;
            w_next_state   = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Gated by reset so every output reads zero while reset is asserted
   assign pipe_csr_gnt = rst && pipe_csr_req &&
                         (((r_state == S_IDLE) && !mret_i) || (r_state == S_DRAIN));

   always_comb begin
      csr_en     = 1'b0;
      csr_addr   = '0;
      csr_opcode = '0;
      csr_wdata  = '0;
      if (w_seq_en) begin
         csr_en     = 1'b1;
         csr_addr   = w_seq_addr;
         csr_opcode = w_seq_op;
         csr_wdata  = w_seq_wdata;
      end else if (pipe_csr_gnt) begin
         csr_en     = 1'b1;
         csr_addr   = pipe_csr_addr;
         csr_opcode = pipe_csr_op;
         csr_wdata  = pipe_csr_wdata;
      end
   end

   assign redirect_pc = r_redirect_pc;
   assign trap_busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_trap_seq
//  Brief    : Directed self-checking bench for csr_trap_seq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_seq;

   logic        clk;
   logic        rst;
   logic [1:0]  irq_i;
   logic        mie_bit;
   logic        mret_i;
   logic        pipe_empty_i;
   logic [31:0] pc_i;
   logic [31:0] mtvec_i;
   logic [31:0] mepc_i;
   logic        pipe_csr_req;
   logic [11:0] pipe_csr_addr;
   logic [2:0]  pipe_csr_op;
   logic [31:0] pipe_csr_wdata;
   logic        pipe_csr_gnt;
   logic        csr_en;
   logic [11:0] csr_addr;
   logic [2:0]  csr_opcode;
   logic [31:0] csr_wdata;
   logic        stop_fetch;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        trap_busy;

   int n_tests = 0;
   int n_fail  = 0;

   csr_trap_seq #(.XLEN(32), .CAUSE_MTI(7), .CAUSE_MEI(11)) dut (
      .clk            (clk),
      .rst            (rst),
      .irq_i          (irq_i),
      .mie_bit        (mie_bit),
      .mret_i         (mret_i),
      .pipe_empty_i   (pipe_empty_i),
      .pc_i           (pc_i),
      .mtvec_i        (mtvec_i),
      .mepc_i         (mepc_i),
      .pipe_csr_req   (pipe_csr_req),
      .pipe_csr_addr  (pipe_csr_addr),
      .pipe_csr_op    (pipe_csr_op),
      .pipe_csr_wdata (pipe_csr_wdata),
      .pipe_csr_gnt   (pipe_csr_gnt),
      .csr_en         (csr_en),
      .csr_addr       (csr_addr),
      .csr_opcode     (csr_opcode),
      .csr_wdata      (csr_wdata),
      .stop_fetch     (stop_fetch),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .trap_busy      (trap_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic en, input logic [11:0] addr,
                          input logic [2:0] op, input logic [31:0] wd);
      chk({tag, ".en"},    32'(csr_en),     32'(en));
      chk({tag, ".addr"},  32'(csr_addr),   32'(addr));
      chk({tag, ".op"},    32'(csr_opcode), 32'(op));
      chk({tag, ".wdata"}, csr_wdata,       wd);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; irq_i = 2'b00; mie_bit = 1'b0; mret_i = 1'b0; pipe_empty_i = 1'b0;
      pc_i = '0; mtvec_i = '0; mepc_i = '0;
      pipe_csr_req = 1'b1; pipe_csr_addr = 12'h305; pipe_csr_op = 3'b001;
      pipe_csr_wdata = 32'h1234;

      // reset state
      step();
      chk("rst.busy",  32'(trap_busy),      32'd0);
      chk("rst.stop",  32'(stop_fetch),     32'd0);
      chk("rst.redv",  32'(redirect_valid), 32'd0);
      chk("rst.redpc", redirect_pc,         32'd0);
      chk("rst.gnt",   32'(pipe_csr_gnt),   32'd0);
      chk("rst.en",    32'(csr_en),         32'd0);
      pipe_csr_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step();

      // 1: timer irq, two drain cycles
      mtvec_i = 32'h100; pc_i = 32'h40; irq_i = 2'b01; mie_bit = 1'b1; pipe_empty_i = 1'b0;
      #1;
      chk("t1.c0.busy", 32'(trap_busy), 32'd0);
      step();
      chk("t1.c1.stop", 32'(stop_fetch), 32'd1);
      chk("t1.c1.busy", 32'(trap_busy),  32'd1);
      chk("t1.c1.en",   32'(csr_en),     32'd0);
      irq_i = 2'b00;
      step();
      chk("t1.c2.stop", 32'(stop_fetch), 32'd1);
      pipe_empty_i = 1'b1;
      step();
      chk_bus("t1.epc", 1'b1, 12'h341, 3'b001, 32'h40);
      pc_i = 32'h99; pipe_empty_i = 1'b0;
      step();
      chk_bus("t1.cause", 1'b1, 12'h342, 3'b001, 32'h8000_0007);
      step();
      chk_bus("t1.mst", 1'b1, 12'h300, 3'b011, 32'h8);
      chk("t1.mst.redv", 32'(redirect_valid), 32'd0);
      step();
      chk("t1.c6.redv",  32'(redirect_valid), 32'd1);
      chk("t1.c6.redpc", redirect_pc,         32'h100);
      chk("t1.c6.stop",  32'(stop_fetch),     32'd1);
      chk("t1.c6.en",    32'(csr_en),         32'd0);
      mie_bit = 1'b0;
      step();
      chk("t1.end.redv",  32'(redirect_valid), 32'd0);
      chk("t1.end.busy",  32'(trap_busy),      32'd0);
      chk("t1.end.redpc", redirect_pc,         32'h100);

      // 2: both interrupts, external wins
      irq_i = 2'b11; mie_bit = 1'b1; pc_i = 32'h40; pipe_empty_i = 1'b1;
      step();
      step();
      chk_bus("t2.epc", 1'b1, 12'h341, 3'b001, 32'h40);
      step();
      chk_bus("t2.cause", 1'b1, 12'h342, 3'b001, 32'h8000_000B);
      step();
      step();
      chk("t2.redv",  32'(redirect_valid), 32'd1);
      chk("t2.redpc", redirect_pc,         32'h100);
      irq_i = 2'b00; mie_bit = 1'b0;
      step();

      // 3: mret, pipeline request blocked in the mret cycle
      mepc_i = 32'h44; mret_i = 1'b1; pipe_csr_req = 1'b1;
      #1;
      chk("t3.idle.gnt", 32'(pipe_csr_gnt), 32'd0);
      chk("t3.idle.en",  32'(csr_en),       32'd0);
      step();
      mret_i = 1'b0;
      #1;
      chk_bus("t3.rs", 1'b1, 12'h300, 3'b010, 32'h8);
      chk("t3.rs.gnt",  32'(pipe_csr_gnt),   32'd0);
      chk("t3.rs.stop", 32'(stop_fetch),     32'd1);
      chk("t3.rs.redv", 32'(redirect_valid), 32'd0);
      pipe_csr_req = 1'b0;
      step();
      chk("t3.redv",  32'(redirect_valid), 32'd1);
      chk("t3.redpc", redirect_pc,         32'h44);
      step();

      // 4: mret and timer irq together
      mret_i = 1'b1; irq_i = 2'b01; mie_bit = 1'b1; pipe_empty_i = 1'b1; pc_i = 32'h80;
      step();
      mret_i = 1'b0; mie_bit = 1'b0;
      #1;
      chk_bus("t4.rs", 1'b1, 12'h300, 3'b010, 32'h8);
      step();
      chk("t4.redv",  32'(redirect_valid), 32'd1);
      chk("t4.redpc", redirect_pc,         32'h44);
      mie_bit = 1'b1;
      step();
      chk("t4.idle.busy", 32'(trap_busy), 32'd0);
      step();
      chk("t4.drain.busy", 32'(trap_busy), 32'd1);
      step();
      chk_bus("t4.epc", 1'b1, 12'h341, 3'b001, 32'h80);
      step();
      chk_bus("t4.cause", 1'b1, 12'h342, 3'b001, 32'h8000_0007);
      step();
      step();
      chk("t4.irq.redv", 32'(redirect_valid), 32'd1);
      irq_i = 2'b00; mie_bit = 1'b0;
      step();

      // 5: pipeline request held through a trap
      pipe_csr_req = 1'b1; pipe_csr_addr = 12'h305; pipe_csr_op = 3'b001;
      pipe_csr_wdata = 32'hDEAD; irq_i = 2'b10; mie_bit = 1'b1; pipe_empty_i = 1'b0;
      pc_i = 32'h60;
      #1;
      chk("t5.idle.gnt", 32'(pipe_csr_gnt), 32'd1);
      chk_bus("t5.idle", 1'b1, 12'h305, 3'b001, 32'hDEAD);
      step();
      chk("t5.drain.gnt", 32'(pipe_csr_gnt), 32'd1);
      chk_bus("t5.drain", 1'b1, 12'h305, 3'b001, 32'hDEAD);
      pipe_empty_i = 1'b1;
      step();
      chk("t5.epc.gnt", 32'(pipe_csr_gnt), 32'd0);
      chk_bus("t5.epc", 1'b1, 12'h341, 3'b001, 32'h60);
      step();
      chk("t5.cause.gnt", 32'(pipe_csr_gnt), 32'd0);
      chk_bus("t5.cause", 1'b1, 12'h342, 3'b001, 32'h8000_000B);
      step();
      chk("t5.mst.gnt", 32'(pipe_csr_gnt), 32'd0);
      chk_bus("t5.mst", 1'b1, 12'h300, 3'b011, 32'h8);
      step();
      chk("t5.redir.gnt", 32'(pipe_csr_gnt), 32'd0);
      chk("t5.redir.en",  32'(csr_en),       32'd0);
      irq_i = 2'b00; mie_bit = 1'b0;
      step();
      chk("t5.idle2.gnt", 32'(pipe_csr_gnt), 32'd1);
      pipe_csr_req = 1'b0;

      // 6: asynchronous reset during WR_CAUSE
      irq_i = 2'b01; mie_bit = 1'b1; pipe_empty_i = 1'b1; pc_i = 32'h50;
      step();
      step();
      step();
      chk("t6.wrc.addr", 32'(csr_addr), 32'h342);
      pipe_csr_req = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("t6.rst.busy",  32'(trap_busy),      32'd0);
      chk("t6.rst.en",    32'(csr_en),         32'd0);
      chk("t6.rst.stop",  32'(stop_fetch),     32'd0);
      chk("t6.rst.redv",  32'(redirect_valid), 32'd0);
      chk("t6.rst.redpc", redirect_pc,         32'd0);
      chk("t6.rst.gnt",   32'(pipe_csr_gnt),   32'd0);
      irq_i = 2'b00; pipe_csr_req = 1'b0;
      step();
      chk("t6.hold.en", 32'(csr_en), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("t6.post.busy", 32'(trap_busy), 32'd0);
      chk("t6.post.en",   32'(csr_en),    32'd0);

      // vectored mtvec, external interrupt
      mtvec_i = 32'h101; irq_i = 2'b10; mie_bit = 1'b1; pipe_empty_i = 1'b1; pc_i = 32'h70;
      step();
      step();
      step();
      chk_bus("t7.cause", 1'b1, 12'h342, 3'b001, 32'h8000_000B);
      step();
      step();
      chk("t7.redv", 32'(redirect_valid), 32'd1);
`ifdef CSR_TRAP_VECTORED_EN
      chk("t7.redpc", redirect_pc, 32'h12C);
`else
      chk("t7.redpc", redirect_pc, 32'h100);
`endif
      irq_i = 2'b00; mie_bit = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
